// File: rtl/epp_pkg.sv
// Shared definitions for the EPP digipot register file: register map and FSM states.
package epp_pkg;

  localparam logic [1:0] ADDR_SEL     = 2'd0;
  localparam logic [1:0] ADDR_DATA    = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_SCRATCH = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    STALL,
    ACK
  } state_t;

endpackage

// File: rtl/epp_digipot_regs_if.sv
// EPP parallel-port bundle: host (master) drives strobes and write data, slave answers.
interface epp_digipot_regs_if;
  logic       epp_nastb;
  logic       epp_ndstb;
  logic       epp_nwrite;
  logic [7:0] epp_d_in;
  logic [7:0] epp_d_out;
  logic       epp_d_oe;
  logic       epp_wait;

  modport master (
    output epp_nastb,
    output epp_ndstb,
    output epp_nwrite,
    output epp_d_in,
    input  epp_d_out,
    input  epp_d_oe,
    input  epp_wait
  );

  modport slave (
    input  epp_nastb,
    input  epp_ndstb,
    input  epp_nwrite,
    input  epp_d_in,
    output epp_d_out,
    output epp_d_oe,
    output epp_wait
  );
endinterface

// File: rtl/epp_sync.sv
// Flop-chain synchronizer for one asynchronous port input.
module epp_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_chain;

  // Shift the asynchronous level through the chain; reset to the inactive level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chain <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      r_chain[0] <= i_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/epp_digipot_regs.sv
// EPP slave register file feeding Digipot_ctrl: SEL/DATA/STATUS/SCRATCH registers,
// one-cycle active-low ctrl strobe per DATA write, handshake stretched while busy.
module epp_digipot_regs
  import epp_pkg::*;
#(
  parameter int unsigned XFER_CYCLES = 80,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  epp_digipot_regs_if.slave  io_epp,
  output logic [1:0]         o_mux,
  output logic [7:0]         o_dato,
  output logic               o_ctrl,
  output logic               o_busy
);

  localparam int unsigned      CNT_W     = $clog2(XFER_CYCLES + 1);
  localparam logic [CNT_W-1:0] XFER_LOAD = CNT_W'(XFER_CYCLES);

  logic w_nastb;
  logic w_ndstb;
  logic w_nwrite;

  epp_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_nastb (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (io_epp.epp_nastb),
    .o_sync  (w_nastb)
  );

  epp_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ndstb (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (io_epp.epp_ndstb),
    .o_sync  (w_ndstb)
  );

  epp_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_nwrite (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (io_epp.epp_nwrite),
    .o_sync  (w_nwrite)
  );

  state_t           r_state;
  logic             r_addr_cyc;  // current cycle was started by the address strobe
  logic             r_rd;        // current cycle is a host read
  logic [1:0]       r_addr;
  logic [1:0]       r_mux;
  logic [7:0]       r_dato;
  logic [7:0]       r_scratch;
  logic [7:0]       r_wdata;     // DATA write value parked while stalled
  logic [7:0]       r_d_out;
  logic             r_d_oe;
  logic             r_wait;
  logic             r_ctrl;
  logic [CNT_W-1:0] r_cnt;

  logic       w_busy;
  logic       w_ready;
  logic       w_strobe_hi;
  logic [7:0] w_rd_data;

  assign w_busy = (r_cnt != '0);
  // The counter is reloaded on the edge after ctrl goes low, so a new transfer may start
  // once the window is in its last cycle; its ctrl then lands on the first non-busy cycle.
  assign w_ready     = r_ctrl && (r_cnt <= CNT_W'(1));
  assign w_strobe_hi = r_addr_cyc ? w_nastb : w_ndstb;

  // Read-data mux for data cycles.
  always_comb begin
    w_rd_data = 8'h00;
    unique case (r_addr)
      ADDR_SEL:     w_rd_data = {6'b0, r_mux};
      ADDR_DATA:    w_rd_data = r_dato;
      ADDR_STATUS:  w_rd_data = {5'b0, w_busy, r_mux};
      ADDR_SCRATCH: w_rd_data = r_scratch;
      default:      w_rd_data = 8'h00;
    endcase
  end

  // Handshake FSM, register file and busy window counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_addr_cyc <= 1'b0;
      r_rd       <= 1'b0;
      r_addr     <= 2'd0;
      r_mux      <= 2'd0;
      r_dato     <= 8'h00;
      r_scratch  <= 8'h00;
      r_wdata    <= 8'h00;
      r_d_out    <= 8'h00;
      r_d_oe     <= 1'b0;
      r_wait     <= 1'b0;
      r_ctrl     <= 1'b1;
      r_cnt      <= '0;
    end else begin
      r_ctrl <= 1'b1;
      // Busy window covers the XFER_CYCLES cycles after the ctrl low cycle.
      if (!r_ctrl) begin
        r_cnt <= XFER_LOAD;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      unique case (r_state)
        IDLE: begin
          if (!w_nastb) begin
            r_addr_cyc <= 1'b1;
            r_rd       <= w_nwrite;
            r_state    <= DECODE;
          end else if (!w_ndstb) begin
            r_addr_cyc <= 1'b0;
            r_rd       <= w_nwrite;
            r_state    <= DECODE;
          end
        end

        DECODE: begin
          r_state <= ACK;
          r_wait  <= 1'b1;
          if (r_addr_cyc) begin
            if (r_rd) begin
              r_d_out <= {6'b0, r_addr};
              r_d_oe  <= 1'b1;
            end else begin
              r_addr <= io_epp.epp_d_in[1:0];
            end
          end else if (r_rd) begin
            r_d_out <= w_rd_data;
            r_d_oe  <= 1'b1;
          end else begin
            unique case (r_addr)
              ADDR_SEL:     r_mux <= io_epp.epp_d_in[1:0];
              ADDR_DATA: begin
                if (w_ready) begin
                  r_dato <= io_epp.epp_d_in;
                  r_ctrl <= 1'b0;
                end else begin
                  r_wdata <= io_epp.epp_d_in;
                  r_state <= STALL;
                  r_wait  <= 1'b0;
                end
              end
              ADDR_SCRATCH: r_scratch <= io_epp.epp_d_in;
              default:      ;  // STATUS is read-only
            endcase
          end
        end

        STALL: begin
          if (w_ready) begin
            r_dato  <= r_wdata;
            r_ctrl  <= 1'b0;
            r_wait  <= 1'b1;
            r_state <= ACK;
          end
        end

        ACK: begin
          if (w_strobe_hi) begin
            r_wait  <= 1'b0;
            r_d_oe  <= 1'b0;
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_epp.epp_d_out = r_d_out;
  assign io_epp.epp_d_oe  = r_d_oe;
  assign io_epp.epp_wait  = r_wait;
  assign o_mux            = r_mux;
  assign o_dato           = r_dato;
  assign o_ctrl           = r_ctrl;
  assign o_busy           = w_busy;

endmodule

// File: tb/tb_epp_digipot_regs.sv
// Randomized bench for epp_digipot_regs against a cycle-stamped behavioural model.
module tb_epp_digipot_regs;

  localparam int XFER = 80;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mux;
  logic [7:0] dato;
  logic       ctrl;
  logic       busy;

  always #5 clk = ~clk;

  epp_digipot_regs_if bus ();

  epp_digipot_regs #(
    .XFER_CYCLES (XFER),
    .SYNC_STAGES (2)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_epp (bus),
    .o_mux  (mux),
    .o_dato (dato),
    .o_ctrl (ctrl),
    .o_busy (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: register contents plus the cycle stamps of every expected ctrl pulse.
  logic [1:0] m_addr = 2'd0;
  logic [1:0] m_sel = 2'd0;
  logic [7:0] m_dato = 8'h00;
  logic [7:0] m_scratch = 8'h00;
  int         q_cyc[$];
  logic [7:0] q_val[$];
  int         last_rst = -1000;
  bit         mon_en = 1'b0;

  function automatic bit busy_exp(input int t);
    foreach (q_cyc[i]) begin
      int c = q_cyc[i];
      if (c < t && t <= c + XFER && !(c <= last_rst && t > last_rst)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int last_live_ctrl();
    if (q_cyc.size() == 0) return -1000;
    if (q_cyc[q_cyc.size()-1] <= last_rst) return -1000;
    return q_cyc[q_cyc.size()-1];
  endfunction

  // Per-cycle check of ctrl, dato at each pulse, and the busy window.
  bit         mon_lo;
  logic [7:0] mon_v;
  always @(negedge clk) begin
    if (mon_en) begin
      mon_lo = 1'b0;
      mon_v  = 8'h00;
      foreach (q_cyc[i]) if (q_cyc[i] == cyc) begin
        mon_lo = 1'b1;
        mon_v  = q_val[i];
      end
      check_val("ctrl", ctrl, !mon_lo);
      if (mon_lo) check_val("dato_at_ctrl", dato, mon_v);
      check_val("busy", busy, busy_exp(cyc));
    end
  end

  task automatic do_reset(input int n);
    int kc[$];
    logic [7:0] kv[$];
    @(negedge clk);
    rst = 1'b1;
    bus.epp_nastb = 1'b1;
    bus.epp_ndstb = 1'b1;
    last_rst = cyc;
    foreach (q_cyc[i]) if (q_cyc[i] <= cyc) begin
      kc.push_back(q_cyc[i]);
      kv.push_back(q_val[i]);
    end
    q_cyc = kc;
    q_val = kv;
    m_addr = 2'd0; m_sel = 2'd0; m_dato = 8'h00; m_scratch = 8'h00;
    repeat (n) @(negedge clk);
    check_val("rst_mux", mux, 2'd0);
    check_val("rst_dato", dato, 8'h00);
    check_val("rst_ctrl", ctrl, 1'b1);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_wait", bus.epp_wait, 1'b0);
    check_val("rst_d_oe", bus.epp_d_oe, 1'b0);
    check_val("rst_d_out", bus.epp_d_out, 8'h00);
    rst = 1'b0;
  endtask

  // One complete EPP cycle with model update and latency/data checks.
  task automatic host_cycle(input bit is_addr, input bit both, input bit wr, input logic [7:0] wdata);
    int s, w, exp_w, lc;
    bit ok;
    logic [7:0] exp_rd;
    @(negedge clk);
    bus.epp_nwrite = !wr;
    bus.epp_d_in   = wdata;
    if (is_addr || both) bus.epp_nastb = 1'b0;
    if (!is_addr || both) bus.epp_ndstb = 1'b0;
    s     = cyc;
    exp_w = s + 4;  // two sync stages, one IDLE cycle, DECODE, then wait
    if (!is_addr && !both && wr && m_addr == 2'd1) begin
      lc = last_live_ctrl();
      if (lc + XFER + 1 > exp_w) exp_w = lc + XFER + 1;
      q_cyc.push_back(exp_w);
      q_val.push_back(wdata);
    end
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.epp_wait === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check_val("wait_timeout", ok, 1'b1);
    if (ok) begin
      w = cyc;
      check_val("wait_rise_cyc", w, exp_w);
      check_val("d_oe_ack", bus.epp_d_oe, !wr);
      if (!wr) begin
        if (is_addr || both) exp_rd = {6'b0, m_addr};
        else begin
          case (m_addr)
            2'd0:    exp_rd = {6'b0, m_sel};
            2'd1:    exp_rd = m_dato;
            2'd2:    exp_rd = {5'b0, busy_exp(w - 1), m_sel};
            default: exp_rd = m_scratch;
          endcase
        end
        check_val("rd_data", bus.epp_d_out, exp_rd);
      end else begin
        if (is_addr || both) m_addr = wdata[1:0];
        else begin
          case (m_addr)
            2'd0:    m_sel = wdata[1:0];
            2'd1:    m_dato = wdata;
            2'd3:    m_scratch = wdata;
            default: ;
          endcase
        end
      end
    end
    bus.epp_nastb = 1'b1;
    bus.epp_ndstb = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.epp_wait === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check_val("wait_release", ok, 1'b1);
    check_val("d_oe_idle", bus.epp_d_oe, 1'b0);
    check_val("mux", mux, m_sel);
  endtask

  initial begin
    bus.epp_nastb  = 1'b1;
    bus.epp_ndstb  = 1'b1;
    bus.epp_nwrite = 1'b1;
    bus.epp_d_in   = 8'h00;
    repeat (2) @(negedge clk);
    do_reset(3);
    mon_en = 1'b1;

    // Address 1 then DATA 0x55.
    host_cycle(1, 0, 1, 8'h01);
    host_cycle(0, 0, 1, 8'h55);
    check_val("dato_55", dato, 8'h55);

    // SEL=2, STATUS during and after busy.
    host_cycle(1, 0, 1, 8'h00);
    host_cycle(0, 0, 1, 8'h02);
    host_cycle(1, 0, 1, 8'h02);
    host_cycle(0, 0, 0, 8'h00);
    repeat (100) @(negedge clk);
    host_cycle(0, 0, 0, 8'h00);

    // Back-to-back DATA writes; second stalls until the window ends.
    host_cycle(1, 0, 1, 8'h01);
    host_cycle(0, 0, 1, 8'hAA);
    host_cycle(0, 0, 1, 8'h0F);
    check_val("dato_0f", dato, 8'h0F);

    // SCRATCH write/read, then both strobes together as an address write.
    host_cycle(1, 0, 1, 8'h03);
    host_cycle(0, 0, 1, 8'hC3);
    host_cycle(0, 0, 0, 8'h00);
    host_cycle(1, 1, 1, 8'hFD);
    host_cycle(1, 0, 0, 8'h00);

    // Reset while a DATA write is stalled behind an active window.
    host_cycle(1, 0, 1, 8'h01);
    host_cycle(0, 0, 1, 8'h11);
    @(negedge clk);
    bus.epp_nwrite = 1'b0;
    bus.epp_d_in   = 8'h77;
    bus.epp_ndstb  = 1'b0;
    repeat (10) @(negedge clk);
    check_val("stall_wait_lo", bus.epp_wait, 1'b0);
    do_reset(3);
    repeat (5) @(negedge clk);
    host_cycle(1, 0, 0, 8'h00);
    host_cycle(1, 0, 1, 8'h01);
    host_cycle(0, 0, 1, 8'h99);

    // Randomized traffic.
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 5))
        0: host_cycle(1, 0, 1, 8'($urandom));
        1: host_cycle(0, 0, 1, 8'($urandom));
        2: host_cycle(0, 0, 0, 8'h00);
        3: host_cycle(1, 0, 0, 8'h00);
        4: repeat ($urandom_range(0, 90)) @(negedge clk);
        default: host_cycle(1, 1, 1, 8'($urandom));
      endcase
    end

    repeat (100) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
